// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and FSM state encoding for the UART frame parser.
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hAA;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    HOLD    = 3'd4
  } parser_state_t;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle between the UART receive path, the parser and the consumer.
// Latency: none, wiring only. UART_PARSER_ACK_EN adds the ack_byte/ack_start pair.
// Backpressure: none on rx; the consumer holds a frame until frame_ack.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_valid;
  logic [LW-1:0] frame_len;
  logic [LW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ack;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          overrun;
  logic          busy;
`ifdef UART_PARSER_ACK_EN
  logic [7:0]    ack_byte;
  logic          ack_start;
`endif

  modport master (
    output rx_data, rx_valid, rd_addr, frame_ack,
    input  frame_valid, frame_len, rd_data, err_chk, err_len, err_timeout, overrun, busy
`ifdef UART_PARSER_ACK_EN
    , input ack_byte, ack_start
`endif
  );

  modport slave (
    input  rx_data, rx_valid, rd_addr, frame_ack,
    output frame_valid, frame_len, rd_data, err_chk, err_len, err_timeout, overrun, busy
`ifdef UART_PARSER_ACK_EN
    , output ack_byte, ack_start
`endif
  );

endinterface

// File: rtl/uart_frame_parser_buf.sv
// Payload register file: MAX_LEN x 8, synchronous write, combinational read, storage not reset.
// Latency: write visible the cycle after we; read is same-cycle.
// Backpressure: none.
module uart_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [LW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [LW-1:0] raddr,
  output logic [7:0]    rdata
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we && (waddr < LW'(MAX_LEN))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Addresses past the array return zero rather than indexing out of range.
  assign rdata = (raddr < LW'(MAX_LEN)) ? mem[raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/LEN/payload/CHK frames from the rx byte stream and holds verified payloads for random read.
// Latency: frame_valid and error pulses one cycle after the deciding strobe; UART_PARSER_ACK_EN adds ack_byte/ack_start.
// Backpressure: none upstream; bytes arriving while a frame is held are dropped and flagged by overrun.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 52080
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_parser_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          overrun_q, overrun_d;
  logic          buf_we;
  logic          in_frame;
  logic          tmo_hit;
  logic [7:0]    buf_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    tmo_d     = '0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    overrun_d = 1'b0;
    buf_we    = 1'b0;
    in_frame  = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    if (in_frame && !bus.rx_valid) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SOF_BYTE)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          if ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else begin
            len_d   = LW'(bus.rx_data);
            chk_d   = bus.rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (bus.rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ bus.rx_data;
          // idx stops at the last slot so it never walks past MAX_LEN-1.
          if (idx_q == (len_q - LW'(1))) begin
            state_d = CHK;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
      end
      CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == chk_q) begin
            state_d = HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        overrun_d = bus.rx_valid;
        if (bus.frame_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe on the terminal cycle keeps the frame alive.
    if (in_frame && !bus.rx_valid && tmo_hit) begin
      err_tmo_d = 1'b1;
      tmo_d     = '0;
      state_d   = IDLE;
    end
  end

  uart_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (bus.rx_data),
    .raddr (bus.rd_addr),
    .rdata (buf_rdata)
  );

  assign bus.frame_valid = (state_q == HOLD);
  assign bus.frame_len   = len_q;
  assign bus.rd_data     = (state_q == HOLD) ? buf_rdata : 8'h00;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_tmo_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef UART_PARSER_ACK_EN
  logic [7:0] ack_byte_q;
  logic       ack_start_q;
  logic       chk_decide;

  assign chk_decide = (state_q == CHK) && bus.rx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_byte_q  <= 8'h00;
      ack_start_q <= 1'b0;
    end else begin
      ack_start_q <= chk_decide;
      if (chk_decide) begin
        ack_byte_q <= (bus.rx_data == chk_q) ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

  assign bus.ack_byte  = ack_byte_q;
  assign bus.ack_start = ack_start_q;
`endif

endmodule
